// File: rtl/score_manager.sv
// Score token sequencer: LFSR spawn, pipelined ball/token collision, timed-token life and colour.
// Optional define SCORE_BLINK_EN makes low-life limited-mode tokens blink.
`timescale 1ns/1ps
module score_manager #(
  parameter int unsigned X_MIN           = 40,
  parameter int unsigned X_MAX           = 600,
  parameter int unsigned Y_MIN           = 40,
  parameter int unsigned Y_MAX           = 440,
  parameter int unsigned HIT_RADIUS      = 24,
  parameter int unsigned LIFE_FRAMES     = 300,
  parameter int unsigned COOLDOWN_FRAMES = 30,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1,
  parameter int unsigned POINTS_W        = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                frame_tick,
  input  logic                mode,
  input  logic [10:0]         ball_x,
  input  logic [10:0]         ball_y,
  input  logic                points_clr,
  output logic [10:0]         score_x,
  output logic [10:0]         score_y,
  output logic [11:0]         score_color,
  output logic [POINTS_W-1:0] points,
  output logic                collect_pulse,
  output logic                timeout_pulse
);

  localparam int unsigned LifeW = $clog2(LIFE_FRAMES + 1);
  localparam int unsigned CoolW = $clog2(COOLDOWN_FRAMES + 2);
  localparam logic [LifeW-1:0] LifeFull    = LifeW'(LIFE_FRAMES);
  localparam logic [LifeW-1:0] LifeHalf    = LifeW'(LIFE_FRAMES / 2);
  localparam logic [LifeW-1:0] LifeQuarter = LifeW'(LIFE_FRAMES / 4);
  localparam logic [CoolW-1:0] CoolFull    = CoolW'(COOLDOWN_FRAMES);
  localparam logic [21:0]      HitSq       = 22'(HIT_RADIUS * HIT_RADIUS);
  localparam logic [10:0]      Hidden      = 11'h400;

  typedef enum logic [1:0] {StIdle, StSpawn, StActive, StCooldown} state_e;

  state_e               state_q;
  logic [15:0]          lfsr_q;
  logic [10:0]          pos_x_q, pos_y_q;
  logic                 mode_q;
  logic [LifeW-1:0]     life_q;
  logic [CoolW-1:0]     cool_q;
  logic [POINTS_W-1:0]  points_q;
  logic                 collect_q, timeout_q;

  logic [10:0] dx_q, dy_q;
  logic        v1_q, v2_q;
  logic [21:0] dist_sq_q;
  logic [9:0]  adx, ady;
  logic [20:0] sq_x, sq_y;
  logic        hit;

  logic [10:0] cx, cy;
  logic        in_range;
  logic        blink_off;
  logic        visible;

  // Galois form of x^16+x^14+x^13+x^11, free-running in every state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_q[0] ? ((lfsr_q >> 1) ^ 16'hB400) : (lfsr_q >> 1);
    end
  end

  assign cx       = {1'b0, lfsr_q[9:0]};
  assign cy       = {2'b0, lfsr_q[15:7]};
  assign in_range = (cx >= 11'(X_MIN)) && (cx <= 11'(X_MAX)) &&
                    (cy >= 11'(Y_MIN)) && (cy <= 11'(Y_MAX));

  // Collision pipeline runs on the latched position so a blinked-off token still collides.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dx_q      <= '0;
      dy_q      <= '0;
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      dist_sq_q <= '0;
    end else begin
      dx_q      <= {1'b0, ball_x[9:0]} - {1'b0, pos_x_q[9:0]};
      dy_q      <= {1'b0, ball_y[9:0]} - {1'b0, pos_y_q[9:0]};
      v1_q      <= !ball_x[10] && !ball_y[10] && (state_q == StActive);
      v2_q      <= v1_q && (state_q == StActive);
      dist_sq_q <= 22'(sq_x) + 22'(sq_y);
    end
  end

  always_comb begin
    adx  = dx_q[10] ? 10'(~dx_q + 11'd1) : dx_q[9:0];
    ady  = dy_q[10] ? 10'(~dy_q + 11'd1) : dy_q[9:0];
    sq_x = 21'(adx) * 21'(adx);
    sq_y = 21'(ady) * 21'(ady);
  end

  assign hit = v2_q && (dist_sq_q <= HitSq);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      pos_x_q   <= '0;
      pos_y_q   <= '0;
      mode_q    <= 1'b0;
      life_q    <= '0;
      cool_q    <= '0;
      points_q  <= '0;
      collect_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      collect_q <= 1'b0;
      timeout_q <= 1'b0;
      if (!enable) begin
        state_q <= StIdle;
      end else begin
        unique case (state_q)
          StIdle: state_q <= StSpawn;
          StSpawn: begin
            if (in_range) begin
              pos_x_q <= cx;
              pos_y_q <= cy;
              mode_q  <= mode;
              life_q  <= LifeFull;
              state_q <= StActive;
            end
          end
          StActive: begin
            // A hit outranks expiry on the same cycle.
            if (hit) begin
              state_q   <= StCooldown;
              cool_q    <= CoolFull;
              collect_q <= 1'b1;
              if (points_q != '1) points_q <= points_q + POINTS_W'(1);
            end else if (mode_q && frame_tick) begin
              if (life_q == LifeW'(1)) begin
                state_q   <= StCooldown;
                cool_q    <= CoolFull;
                timeout_q <= 1'b1;
              end else begin
                life_q <= life_q - LifeW'(1);
              end
            end
          end
          StCooldown: begin
            if (frame_tick) begin
              if (cool_q <= CoolW'(1)) begin
                state_q <= StSpawn;
                cool_q  <= '0;
              end else begin
                cool_q <= cool_q - CoolW'(1);
              end
            end
          end
          default: state_q <= StIdle;
        endcase
      end
      // Placed last so a clear beats a same-cycle collect.
      if (points_clr) points_q <= '0;
    end
  end

`ifdef SCORE_BLINK_EN
  logic [2:0] blink_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blink_q <= '0;
    end else if (state_q != StActive) begin
      blink_q <= '0;
    end else if (frame_tick) begin
      blink_q <= blink_q + 3'd1;
    end
  end

  assign blink_off = mode_q && (life_q < LifeW'(LIFE_FRAMES / 8)) && blink_q[2];
`else
  assign blink_off = 1'b0;
`endif

  assign visible = (state_q == StActive) && !blink_off;
  assign score_x = visible ? pos_x_q : Hidden;
  assign score_y = visible ? pos_y_q : Hidden;

  always_comb begin
    score_color = 12'h000;
    if (state_q == StActive) begin
      if (!mode_q || (life_q > LifeHalf)) begin
        score_color = 12'h0F0;
      end else if (life_q > LifeQuarter) begin
        score_color = 12'hFF0;
      end else begin
        score_color = 12'hF00;
      end
    end
  end

  assign points        = points_q;
  assign collect_pulse = collect_q;
  assign timeout_pulse = timeout_q;

endmodule

// File: tb/tb_score_manager.sv
// Directed bench for score_manager: spawn, collect latency, lifetime colours, priorities, reset.
`timescale 1ns/1ps
module tb_score_manager;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0;
  logic        frame_tick = 1'b0;
  logic        mode = 1'b0;
  logic [10:0] ball_x = 11'h400;
  logic [10:0] ball_y = 11'h400;
  logic        points_clr = 1'b0;
  logic [10:0] score_x, score_y;
  logic [11:0] score_color;
  logic [7:0]  points;
  logic        collect_pulse, timeout_pulse;

  int n_vec = 0;
  int n_fail = 0;

  logic [10:0] first_x, first_y;
  int          first_cyc;

  // Reference LFSR; m_prev holds the value the DUT sampled on the latest edge.
  logic [15:0] m_lfsr, m_prev;

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_lfsr <= 16'hACE1;
      m_prev <= 16'hACE1;
    end else begin
      m_prev <= m_lfsr;
      m_lfsr <= m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
    end
  end

  score_manager dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .frame_tick   (frame_tick),
    .mode         (mode),
    .ball_x       (ball_x),
    .ball_y       (ball_y),
    .points_clr   (points_clr),
    .score_x      (score_x),
    .score_y      (score_y),
    .score_color  (score_color),
    .points       (points),
    .collect_pulse(collect_pulse),
    .timeout_pulse(timeout_pulse)
  );

  task automatic ticks(input int n);
    repeat (n) begin
      frame_tick = 1'b1;
      @(negedge clk);
    end
    frame_tick = 1'b0;
  endtask

  task automatic wait_visible(output bit ok, output int cyc);
    ok = 1'b0;
    cyc = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      cyc++;
      if (score_x !== 11'h400) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic respawn(output bit ok);
    int cyc;
    ticks(30);
    wait_visible(ok, cyc);
  endtask

  // Puts the ball 10,10 off the token centre and waits for the collect pulse.
  task automatic hit_token(output bit ok, output int lat);
    ball_x = score_x + 11'd10;
    ball_y = score_y + 11'd10;
    ok = 1'b0;
    lat = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      lat++;
      if (collect_pulse === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    ball_x = 11'h400;
    ball_y = 11'h400;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++; if (score_x !== 11'h400) begin n_fail++; $display("FAIL reset_score_x: got %h want 400", score_x); end
    n_vec++; if (score_y !== 11'h400) begin n_fail++; $display("FAIL reset_score_y: got %h want 400", score_y); end
    n_vec++; if (score_color !== 12'h000) begin n_fail++; $display("FAIL reset_color: got %h want 000", score_color); end
    n_vec++; if (points !== 8'h00) begin n_fail++; $display("FAIL reset_points: got %h want 00", points); end
    n_vec++; if (collect_pulse !== 1'b0 || timeout_pulse !== 1'b0) begin
      n_fail++; $display("FAIL reset_pulses: got %b%b want 00", collect_pulse, timeout_pulse); end
  endtask

  task automatic test_spawn;
    bit ok;
    rst = 1'b1;
    enable = 1'b1;
    mode = 1'b0;
    wait_visible(ok, first_cyc);
    first_x = score_x;
    first_y = score_y;
    n_vec++; if (!ok) begin n_fail++; $display("FAIL spawn_timeout: got hidden want visible"); end
    n_vec++; if (score_x < 11'd40 || score_x > 11'd600) begin n_fail++; $display("FAIL spawn_x_range: got %0d want 40..600", score_x); end
    n_vec++; if (score_y < 11'd40 || score_y > 11'd440) begin n_fail++; $display("FAIL spawn_y_range: got %0d want 40..440", score_y); end
    n_vec++; if (score_x !== {1'b0, m_prev[9:0]}) begin n_fail++; $display("FAIL spawn_x_lfsr: got %h want %h", score_x, {1'b0, m_prev[9:0]}); end
    n_vec++; if (score_y !== {2'b0, m_prev[15:7]}) begin n_fail++; $display("FAIL spawn_y_lfsr: got %h want %h", score_y, {2'b0, m_prev[15:7]}); end
    n_vec++; if (score_color !== 12'h0F0) begin n_fail++; $display("FAIL spawn_color: got %h want 0F0", score_color); end
    n_vec++; if (points !== 8'h00) begin n_fail++; $display("FAIL spawn_points: got %h want 00", points); end
  endtask

  task automatic test_collect;
    bit ok;
    int lat;
    hit_token(ok, lat);
    n_vec++; if (!ok || lat < 2 || lat > 3) begin n_fail++; $display("FAIL collect_latency: got %0d want 2..3", lat); end
    n_vec++; if (points !== 8'h01) begin n_fail++; $display("FAIL collect_points: got %h want 01", points); end
    n_vec++; if (score_x !== 11'h400 || score_color !== 12'h000) begin
      n_fail++; $display("FAIL collect_hidden: got %h/%h want 400/000", score_x, score_color); end
    n_vec++; if (timeout_pulse !== 1'b0) begin n_fail++; $display("FAIL collect_no_timeout: got %b want 0", timeout_pulse); end
    @(negedge clk);
    n_vec++; if (collect_pulse !== 1'b0) begin n_fail++; $display("FAIL collect_one_cycle: got %b want 0", collect_pulse); end
    ticks(29);
    n_vec++; if (score_x !== 11'h400) begin n_fail++; $display("FAIL cooldown_29: got %h want 400", score_x); end
    ticks(1);
    wait_visible(ok, lat);
    n_vec++; if (!ok || score_x !== {1'b0, m_prev[9:0]}) begin
      n_fail++; $display("FAIL respawn_pos: got %h want %h", score_x, {1'b0, m_prev[9:0]}); end
  endtask

  task automatic test_lifetime;
    bit ok;
    int cyc;
    mode = 1'b1;
    enable = 1'b0;
    @(negedge clk);
    enable = 1'b1;
    wait_visible(ok, cyc);
    mode = 1'b0;  // must not affect the live token
    n_vec++; if (!ok || score_color !== 12'h0F0) begin n_fail++; $display("FAIL life_start: got %h want 0F0", score_color); end
    ticks(149);
    n_vec++; if (score_color !== 12'h0F0) begin n_fail++; $display("FAIL life_149: got %h want 0F0", score_color); end
    ticks(1);
    n_vec++; if (score_color !== 12'hFF0) begin n_fail++; $display("FAIL life_150: got %h want FF0", score_color); end
    ticks(74);
    n_vec++; if (score_color !== 12'hFF0) begin n_fail++; $display("FAIL life_224: got %h want FF0", score_color); end
    ticks(1);
    n_vec++; if (score_color !== 12'hF00) begin n_fail++; $display("FAIL life_225: got %h want F00", score_color); end
    ticks(74);
    n_vec++; if (timeout_pulse !== 1'b0 || score_x === 11'h400) begin
      n_fail++; $display("FAIL life_299: got tp=%b x=%h want tp=0 visible", timeout_pulse, score_x); end
    ticks(1);
    n_vec++; if (timeout_pulse !== 1'b1) begin n_fail++; $display("FAIL life_timeout: got %b want 1", timeout_pulse); end
    n_vec++; if (points !== 8'h01 || score_x !== 11'h400) begin
      n_fail++; $display("FAIL life_after: got pts=%h x=%h want 01/400", points, score_x); end
  endtask

  task automatic test_hit_and_expiry;
    bit ok;
    mode = 1'b1;
    respawn(ok);
    mode = 1'b0;
    ticks(299);
    ball_x = score_x;
    ball_y = score_y;
    @(negedge clk);
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    n_vec++; if (!ok || collect_pulse !== 1'b1 || timeout_pulse !== 1'b0) begin
      n_fail++; $display("FAIL hit_vs_expiry: got c=%b t=%b want c=1 t=0", collect_pulse, timeout_pulse); end
    n_vec++; if (points !== 8'h02) begin n_fail++; $display("FAIL hit_vs_expiry_pts: got %h want 02", points); end
    ball_x = 11'h400;
    ball_y = 11'h400;
  endtask

  task automatic test_saturate_and_clear;
    bit ok, all_ok;
    int lat;
    all_ok = 1'b1;
    for (int i = 0; i < 253; i++) begin
      respawn(ok);
      all_ok &= ok;
      hit_token(ok, lat);
      all_ok &= ok;
    end
    n_vec++; if (!all_ok || points !== 8'hFF) begin n_fail++; $display("FAIL sat_reach: got %h want FF", points); end
    respawn(ok);
    hit_token(ok, lat);
    n_vec++; if (!ok || points !== 8'hFF) begin n_fail++; $display("FAIL sat_hold: got %h want FF", points); end
    respawn(ok);
    ball_x = score_x;
    ball_y = score_y;
    @(negedge clk);
    @(negedge clk);
    points_clr = 1'b1;
    @(negedge clk);
    points_clr = 1'b0;
    n_vec++; if (!ok || collect_pulse !== 1'b1 || points !== 8'h00) begin
      n_fail++; $display("FAIL clr_with_collect: got c=%b pts=%h want 1/00", collect_pulse, points); end
    ball_x = 11'h400;
    ball_y = 11'h400;
  endtask

  task automatic test_disable_and_reset;
    bit ok, seen;
    int lat, cyc;
    logic [10:0] px, py;
    respawn(ok);
    hit_token(ok, lat);
    respawn(ok);
    px = score_x;
    py = score_y;
    enable = 1'b0;
    @(negedge clk);
    n_vec++; if (score_x !== 11'h400 || score_y !== 11'h400 || score_color !== 12'h000) begin
      n_fail++; $display("FAIL disable_hidden: got %h,%h,%h want 400,400,000", score_x, score_y, score_color); end
    ball_x = px;
    ball_y = py;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      seen |= collect_pulse | timeout_pulse;
    end
    n_vec++; if (seen !== 1'b0 || points !== 8'h01) begin
      n_fail++; $display("FAIL disable_quiet: got pulse=%b pts=%h want 0/01", seen, points); end
    ball_x = 11'h400;
    ball_y = 11'h400;
    enable = 1'b1;
    wait_visible(ok, cyc);
    hit_token(ok, lat);
    ticks(10);
    rst = 1'b0;
    #1;
    n_vec++; if (score_x !== 11'h400 || score_color !== 12'h000 || points !== 8'h00 ||
                 collect_pulse !== 1'b0 || timeout_pulse !== 1'b0) begin
      n_fail++; $display("FAIL async_reset: got x=%h col=%h pts=%h c=%b t=%b want 400/000/00/0/0",
                         score_x, score_color, points, collect_pulse, timeout_pulse); end
    @(negedge clk);
    rst = 1'b1;
    wait_visible(ok, cyc);
    n_vec++; if (!ok || score_x !== first_x || score_y !== first_y || cyc != first_cyc) begin
      n_fail++; $display("FAIL reseed: got %h,%h@%0d want %h,%h@%0d", score_x, score_y, cyc,
                         first_x, first_y, first_cyc); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_spawn();
    test_collect();
    test_lifetime();
    test_hit_and_expiry();
    test_saturate_and_clear();
    test_disable_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/score_manager.md
Name: score_manager

Overview:
- Controller that sequences the on-screen score token consumed by the score drawing block.
- Picks spawn positions with an LFSR and detects ball/token collision with a pipelined squared-distance check.
- In limited mode, runs a per-token lifetime and grades the token colour by remaining life.
- Drives score_x/score_y/score_color to the drawer and keeps the player's point count; sits between the ball physics block and the VGA renderer.

Parameters:
- X_MIN, 40, lowest legal spawn x (pixels)
- X_MAX, 600, highest legal spawn x
- Y_MIN, 40, lowest legal spawn y
- Y_MAX, 440, highest legal spawn y
- HIT_RADIUS, 24, collision radius (token radius plus ball radius), pixels
- LIFE_FRAMES, 300, token lifetime in limited mode, frames
- COOLDOWN_FRAMES, 30, hidden interval between tokens, frames
- LFSR_SEED, 16'hACE1, LFSR reset value; must be nonzero
- POINTS_W, 8, width of the point counter

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-low
- enable  in  1  level; game running
- frame_tick  in  1  one-cycle pulse per video frame
- mode  in  1  1 = LIMITED (timed tokens), 0 = unlimited
- ball_x  in  11  ball centre x; bit10 set = off-screen/invalid
- ball_y  in  11  ball centre y; bit10 set = off-screen/invalid
- points_clr  in  1  synchronous clear of the point counter
- score_x  out  11  token centre x to the drawer; 11'h400 = hidden
- score_y  out  11  token centre y to the drawer; 11'h400 = hidden
- score_color  out  12  RGB444 token colour
- points  out  POINTS_W  collected-token count
- collect_pulse  out  1  one cycle per collected token
- timeout_pulse  out  1  one cycle per expired token

Behaviour:
- Reset values: state IDLE; score_x = score_y = 11'h400; score_color = 12'h000; points = 0; both pulses 0; lfsr = LFSR_SEED; life and cooldown counters 0.
- LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11. Advances every clock in every state, including IDLE.
- Hidden encoding: while hidden, score_x and score_y both drive 11'h400, so the drawer's bit10 test suppresses drawing.
- States:
  - IDLE: token hidden. Go to SPAWN when enable=1.
  - SPAWN: candidate cx = {1'b0, lfsr[9:0]}, cy = {2'b0, lfsr[15:7]}.
    - If X_MIN<=cx<=X_MAX and Y_MIN<=cy<=Y_MAX: register cx/cy to score_x/score_y, latch mode into mode_q, load life = LIFE_FRAMES, go to ACTIVE.
    - Otherwise retry next cycle. Token stays hidden throughout SPAWN.
  - ACTIVE: token visible; collision checked every cycle.
    - Hit: go to COOLDOWN, points += 1 (saturating at all-ones), collect_pulse = 1 for that cycle.
    - Else if mode_q=1 and frame_tick=1 and life==1: go to COOLDOWN, timeout_pulse = 1, points unchanged.
    - Else if mode_q=1 and frame_tick=1: life -= 1.
  - COOLDOWN: token hidden. Load cooldown = COOLDOWN_FRAMES on entry; decrement on frame_tick; go to SPAWN when it reaches 0.
- Disable: enable=0 in any state forces IDLE on the next edge and hides the token. points is held; no pulses fire.
- Collision datapath:
  - dx = ball_x[9:0] - score_x[9:0] as 11-bit signed; dy likewise.
  - Squares are 21-bit; sum is 22-bit; both register stages are unsigned.
  - Stage 1 registers dx and dy. Stage 2 registers dist_sq. hit = (dist_sq <= HIT_RADIUS^2) AND a valid bit.
  - Valid bit: ball bit10 clear AND ACTIVE state, delayed with the pipeline. Total latency 2 cycles.
  - The valid pipeline is flushed when the state leaves ACTIVE, so a stale hit cannot count against the next token.
- Colour:
  - mode_q=0: 12'h0F0.
  - mode_q=1: life > LIFE_FRAMES/2 gives 12'h0F0; life > LIFE_FRAMES/4 gives 12'hFF0; otherwise 12'hF00.
  - Hidden states: 12'h000.
- Simultaneous events:
  - Hit and expiry in the same cycle: the hit wins (collect, no timeout).
  - points_clr with a collect in the same cycle: points = 0.
- mode changes while ACTIVE take effect at the next spawn only.

Optional Feature:
- SCORE_BLINK_EN defined: in ACTIVE with mode_q=1 and life < LIFE_FRAMES/8, the token blinks.
  - A 3-bit frame counter toggles visibility every 4 frames; while blinked off, score_x/score_y drive 11'h400.
  - Collision detection continues during blinked-off frames: it uses the latched position, not the hidden output.
- SCORE_BLINK_EN undefined: no blink logic; the token stays continuously visible in ACTIVE.

Test Plan:
- Reset, enable=1, ball off-screen (ball_x=11'h400) -> token appears within the SPAWN retry window; score_x in [40,600]; score_y in [40,440]; points=0.
- ACTIVE token at (300,200); ball driven to (310,210); dist_sq=200 <= 576 -> collect_pulse exactly 2-3 cycles later; points=1; token hidden; respawn after 30 frame_ticks.
- mode=1, ball far away, 300 frame_ticks -> colour 12'h0F0, then 12'hFF0 after frame 150, then 12'hF00 after frame 225; timeout_pulse at tick 300; points unchanged.
- Hit and final frame_tick in the same cycle -> collect_pulse=1, timeout_pulse=0, points incremented.
- points=8'hFF plus a collect -> points stays 8'hFF. points_clr together with a collect -> points=0.
- Deassert enable mid-ACTIVE, then assert rst low mid-COOLDOWN -> IDLE, 11'h400 outputs, no pulses; LFSR returns to 16'hACE1 after rst.
